// File: rtl/mem_pkg.sv
// Shared store-path encodings: access sizes, fault codes, aligner states.
// The alignment rule lives here so every user sees the same definition.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_HALF  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;
   localparam logic [1:0] SZ_DWORD = 2'b11;

   localparam logic [1:0] FLT_NONE     = 2'b00;
   localparam logic [1:0] FLT_MISALIGN = 2'b01;
   localparam logic [1:0] FLT_TIMEOUT  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BEAT0,
      ST_BEAT1,
      ST_DONE,
      ST_FAULT
   } st_state_e;

   function automatic logic misaligned(
      input logic [1:0] size,
      input logic [2:0] a
   );
      logic bad;
      case (size)
         SZ_HALF:  bad = a[0];
         SZ_WORD:  bad = |a[1:0];
         SZ_DWORD: bad = |a;
         default:  bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/store_lane_pack.sv
// Replicates store data across byte lanes and forms byte enables
// for one 32-bit memory beat.
module store_lane_pack
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic [31:0] data,
   output logic [31:0] wdata,
   output logic [3:0]  be
);

   always_comb begin
      wdata = data;
      be    = 4'b1111;
      case (size)
         SZ_BYTE: begin
            wdata = {4{data[7:0]}};
            be    = 4'b0001 << lane;
         end
         SZ_HALF: begin
            wdata = {2{data[15:0]}};
            be    = lane[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wdata = data;
            be    = 4'b1111;
         end
      endcase
   end

endmodule

// File: rtl/store_data_aligner.sv
// Store path from EX/MEM to the data-memory port: alignment check,
// lane packing, double-word split into two beats, ack timeout.
module store_data_aligner
   import mem_pkg::*;
#(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [31:0] st_addr,
   input  logic [63:0] st_data,
   input  logic [1:0]  st_size,
   output logic        st_done,
   output logic        st_fault,
   output logic [1:0]  st_fault_code,
   output logic        mem_req,
   input  logic        mem_ack,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be
);

   localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0] LIM = CW'(ACK_TIMEOUT - 1);

   st_state_e   state;
   logic [1:0]  size_q;
   logic [31:0] hi_q;
   logic [CW-1:0] cnt;
   logic        expire;

   logic [1:0]  pk_size;
   logic [31:0] pk_data;
   logic [31:0] pk_wdata;
   logic [3:0]  pk_be;

   // Beat 0 packs the incoming request; beat 1 is always the upper word.
   assign pk_size = (state == ST_IDLE) ? st_size : SZ_WORD;
   assign pk_data = (state == ST_IDLE) ? st_data[31:0] : hi_q;
   assign expire  = (ACK_TIMEOUT != 0) && (cnt == LIM);

   store_lane_pack u_pack (
      .size  (pk_size),
      .lane  (st_addr[1:0]),
      .data  (pk_data),
      .wdata (pk_wdata),
      .be    (pk_be)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         st_ready      <= 1'b1;
         st_done       <= 1'b0;
         st_fault      <= 1'b0;
         st_fault_code <= FLT_NONE;
         mem_req       <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mem_be        <= '0;
         size_q        <= SZ_BYTE;
         hi_q          <= '0;
         cnt           <= '0;
      end else begin
         st_done  <= 1'b0;
         st_fault <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (st_valid) begin
                  st_ready <= 1'b0;
                  size_q   <= st_size;
                  hi_q     <= st_data[63:32];
                  cnt      <= '0;
                  if (misaligned(st_size, st_addr[2:0])) begin
                     state         <= ST_FAULT;
                     st_fault      <= 1'b1;
                     st_fault_code <= FLT_MISALIGN;
                  end else begin
                     state     <= ST_BEAT0;
                     mem_req   <= 1'b1;
                     mem_addr  <= {st_addr[31:2], 2'b00};
                     mem_wdata <= pk_wdata;
                     mem_be    <= pk_be;
                  end
               end
            end
            ST_BEAT0, ST_BEAT1: begin
               // An ack on the final allowed cycle still completes the beat.
               if (mem_ack) begin
                  cnt <= '0;
                  if (state == ST_BEAT0 && size_q == SZ_DWORD) begin
                     state     <= ST_BEAT1;
                     mem_addr  <= mem_addr + 32'd4;
                     mem_wdata <= pk_wdata;
                     mem_be    <= pk_be;
                  end else begin
                     state   <= ST_DONE;
                     mem_req <= 1'b0;
                     st_done <= 1'b1;
                  end
               end else if (expire) begin
                  state         <= ST_FAULT;
                  mem_req       <= 1'b0;
                  st_fault      <= 1'b1;
                  st_fault_code <= FLT_TIMEOUT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE, ST_FAULT: begin
               state    <= ST_IDLE;
               st_ready <= 1'b1;
            end
            default: begin
               state    <= ST_IDLE;
               st_ready <= 1'b1;
               mem_req  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_store_data_aligner.sv
// Directed bench for store_data_aligner with a transaction-level
// reference model of expected memory beats and completions.
module tb_store_data_aligner;
   import mem_pkg::*;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        st_valid = 1'b0;
   logic        st_ready;
   logic [31:0] st_addr = '0;
   logic [63:0] st_data = '0;
   logic [1:0]  st_size = '0;
   logic        st_done;
   logic        st_fault;
   logic [1:0]  st_fault_code;
   logic        mem_req;
   logic        mem_ack;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;

   store_data_aligner #(.ACK_TIMEOUT(TMO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .st_valid      (st_valid),
      .st_ready      (st_ready),
      .st_addr       (st_addr),
      .st_data       (st_data),
      .st_size       (st_size),
      .st_done       (st_done),
      .st_fault      (st_fault),
      .st_fault_code (st_fault_code),
      .mem_req       (mem_req),
      .mem_ack       (mem_ack),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_be        (mem_be)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
   } beat_t;

   beat_t beats[$];
   int    ends[$];
   int    ack_wait = 0;
   bit    idle_ack = 1'b0;
   int    ce;

   // Reference: what a store must look like on the memory port.
   task automatic model(input logic [31:0] a, input logic [63:0] d,
                        input logic [1:0] sz, input int endcode);
      beat_t b;
      int    al;
      al = (sz == 2'd3) ? 8 : (1 << sz);
      if ((a % al) != 0) begin
         ends.push_back(1);
         return;
      end
      b.a = a & ~32'h3;
      case (sz)
         2'd0: begin
            b.d  = d[7:0] * 32'h01010101;
            b.be = 4'(1 << (a % 4));
         end
         2'd1: begin
            b.d  = d[15:0] * 32'h00010001;
            b.be = 4'(3 << (a % 4));
         end
         default: begin
            b.d  = d[31:0];
            b.be = 4'hF;
         end
      endcase
      beats.push_back(b);
      if (sz == 2'd3) begin
         b.a = b.a + 32'd4;
         b.d = d[63:32];
         beats.push_back(b);
      end
      ends.push_back(endcode);
   endtask

   // Memory responder: ack after ack_wait idle cycles of each beat.
   initial begin
      int w;
      w = 0;
      mem_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && mem_req) begin
            if (ack_wait >= 0 && w == ack_wait) begin
               mem_ack = 1'b1;
               w = 0;
            end else begin
               mem_ack = 1'b0;
               w++;
            end
         end else begin
            mem_ack = idle_ack;
            w = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_req) begin
            chk("ready_while_busy", st_ready, 0);
            if (beats.size() == 0) begin
               chk("unexpected_req", 1, 0);
            end else begin
               chk("mem_addr", mem_addr, beats[0].a);
               chk("mem_wdata", mem_wdata, beats[0].d);
               chk("mem_be", mem_be, beats[0].be);
               if (mem_ack) void'(beats.pop_front());
            end
         end
         if (st_done || st_fault) begin
            if (ends.size() == 0) begin
               chk("unexpected_end", 1, 0);
            end else begin
               ce = ends.pop_front();
               chk("end_kind", {st_fault, st_done},
                   (ce == 0) ? 2'b01 : 2'b10);
               if (ce != 0) chk("fault_code", st_fault_code, ce);
               if (ce == 2 && beats.size() > 0) void'(beats.pop_front());
            end
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [63:0] d,
                        input logic [1:0] sz, input int endcode);
      int n;
      n = 0;
      @(negedge clk);
      while (!st_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_issue", st_ready, 1);
      model(a, d, sz, endcode);
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      st_size  = sz;
      @(posedge clk);
      #1;
      st_valid = 1'b0;
   endtask

   task automatic wait_end(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(st_done || st_fault) && cyc < 40);
      if (!(st_done || st_fault)) chk("end_wait_expired", 0, 1);
   endtask

   initial begin
      int     c;
      int     n;
      longint t1;

      repeat (2) @(negedge clk);
      chk("rst_ready", st_ready, 1);
      chk("rst_req", mem_req, 0);
      chk("rst_done", st_done, 0);
      chk("rst_fault", st_fault, 0);
      chk("rst_code", st_fault_code, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_be", mem_be, 0);
      rst_n = 1'b1;

      // byte at lane 3, ack immediately
      ack_wait = 0;
      issue(32'h1003, 64'hA5, 2'd0, 0);
      @(negedge clk);
      chk("t1_req", mem_req, 1);
      chk("t1_addr", mem_addr, 32'h1000);
      chk("t1_wdata", mem_wdata, 32'hA5A5A5A5);
      chk("t1_be", mem_be, 4'b1000);
      wait_end(c);
      chk("t1_done", st_done, 1);
      chk("t1_latency", c, 1);
      @(negedge clk);
      chk("t1_ready_back", st_ready, 1);
      chk("t1_req_low", mem_req, 0);

      // half, ack on the 4th request cycle (the timeout limit)
      ack_wait = 3;
      issue(32'h2002, 64'h1234, 2'd1, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t2_req", mem_req, 1);
         chk("t2_addr", mem_addr, 32'h2000);
         chk("t2_wdata", mem_wdata, 32'h12341234);
         chk("t2_be", mem_be, 4'b1100);
      end
      @(negedge clk);
      chk("t2_done", st_done, 1);

      // double word split
      ack_wait = 0;
      issue(32'h3008, 64'h11223344_55667788, 2'd3, 0);
      @(negedge clk);
      chk("t3_b0_addr", mem_addr, 32'h3008);
      chk("t3_b0_data", mem_wdata, 32'h55667788);
      @(negedge clk);
      chk("t3_b1_req", mem_req, 1);
      chk("t3_b1_addr", mem_addr, 32'h300C);
      chk("t3_b1_data", mem_wdata, 32'h11223344);
      @(negedge clk);
      chk("t3_done", st_done, 1);
      chk("t3_req_low", mem_req, 0);

      // ack while idle must be ignored
      idle_ack = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_ack_no_done", st_done, 0);
         chk("idle_ack_ready", st_ready, 1);
      end
      idle_ack = 1'b0;

      // misaligned word
      issue(32'h4002, 64'hDEADBEEF, 2'd2, 1);
      @(negedge clk);
      chk("t4_fault", st_fault, 1);
      chk("t4_code", st_fault_code, 2'b01);
      chk("t4_no_req", mem_req, 0);
      @(negedge clk);
      chk("t4_ready", st_ready, 1);
      chk("t4_fault_low", st_fault, 0);
      chk("t4_code_held", st_fault_code, 2'b01);

      // no ack at all: timeout after TMO request cycles
      ack_wait = -1;
      issue(32'h5001, 64'h3C, 2'd0, 2);
      n = 0;
      c = 0;
      while (!st_fault && c < 20) begin
         @(negedge clk);
         if (mem_req) n++;
         c++;
      end
      chk("t5_req_cycles", n, TMO);
      chk("t5_fault", st_fault, 1);
      chk("t5_code", st_fault_code, 2'b10);

      // back-to-back zero-wait words: 3 cycles per store
      ack_wait = 0;
      issue(32'h6000, 64'hCAFEF00D, 2'd2, 0);
      wait_end(c);
      t1 = $time;
      issue(32'h6004, 64'h0BADC0DE, 2'd2, 0);
      wait_end(c);
      chk("b2b_period", ($time - t1) / 10, 3);

      // top-of-memory double word
      ack_wait = 1;
      issue(32'hFFFFFFF8, 64'h89ABCDEF_01234567, 2'd3, 0);
      wait_end(c);
      chk("top_dw_done", st_done, 1);

      // reset in beat 1
      ack_wait = 0;
      issue(32'h7000, 64'hAAAA5555_12345678, 2'd3, 0);
      @(negedge clk);
      @(negedge clk);
      chk("t6_in_beat1", mem_addr, 32'h7004);
      rst_n = 1'b0;
      #1;
      beats.delete();
      ends.delete();
      chk("t6_req", mem_req, 0);
      chk("t6_addr", mem_addr, 0);
      chk("t6_wdata", mem_wdata, 0);
      chk("t6_be", mem_be, 0);
      chk("t6_ready", st_ready, 1);
      chk("t6_code", st_fault_code, 0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(32'h7002, 64'h5A, 2'd0, 0);
      @(negedge clk);
      chk("t6_byte_be", mem_be, 4'b0100);
      chk("t6_byte_data", mem_wdata, 32'h5A5A5A5A);
      wait_end(c);
      chk("t6_byte_done", st_done, 1);

      repeat (2) @(negedge clk);
      chk("model_drained", beats.size() + ends.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
